// File: rtl/clock_div_gen.sv
// Multi-channel programmable clock divider with glitch-free divisor updates and sync alignment.
// Optional CLKGEN_GATE_EN adds per-channel run_en gating that stops a channel at the end of its period.
module clock_div_gen #(
  parameter int NUM_CH = 2,
  parameter int DIV_W = 8,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {8'd8, 8'd2},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
`ifdef CLKGEN_GATE_EN
  input  logic [NUM_CH-1:0] run_en,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_stb,
  output logic [NUM_CH-1:0] tc_stb
);

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic [DIV_W-1:0] cnt     [NUM_CH];
  logic [DIV_W-1:0] div     [NUM_CH];
  logic [DIV_W-1:0] nxt     [NUM_CH];
  logic [DIV_W-1:0] cnt_nxt [NUM_CH];
  logic [DIV_W-1:0] div_nxt [NUM_CH];
  logic [NUM_CH-1:0] pending, pending_nxt, restart;
  logic [NUM_CH-1:0] clk_nxt, rise_nxt, tc_nxt;
  logic ch_ok, accept;

  function automatic logic [DIV_W-1:0] clamp(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  always_comb begin
    ch_ok     = ({1'b0, cfg_ch} < NUM_CH_L);
    cfg_ready = ch_ok ? ~pending[cfg_ch] : 1'b1;
    accept    = cfg_valid & cfg_ready & ch_ok;
  end

  // Outputs are registered from the next-state counter so they always match the count they describe.
  always_comb begin
    pending_nxt = pending;
    restart     = '0;
    clk_nxt     = '0;
    rise_nxt    = '0;
    tc_nxt      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      restart[i] = sync | (cnt[i] == div[i] - DIV_W'(1));
      cnt_nxt[i] = restart[i] ? '0 : cnt[i] + DIV_W'(1);
`ifdef CLKGEN_GATE_EN
      if (!restart[i] && (cnt[i] == '0) && !run_en[i])
        cnt_nxt[i] = '0;
`endif
      div_nxt[i] = div[i];
      if (restart[i] && pending[i]) begin
        div_nxt[i]     = nxt[i];
        pending_nxt[i] = 1'b0;
      end
      if (accept && (cfg_ch == CH_W'(i)))
        pending_nxt[i] = 1'b1;
      clk_nxt[i]  = (cnt_nxt[i] >= (div_nxt[i] >> 1));
      rise_nxt[i] = (cnt_nxt[i] == (div_nxt[i] >> 1));
      tc_nxt[i]   = (cnt_nxt[i] == div_nxt[i] - DIV_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        div[i] <= clamp(DIV_INIT[i*DIV_W +: DIV_W]);
        nxt[i] <= '0;
      end
      pending  <= '0;
      clk_out  <= '0;
      rise_stb <= '0;
      tc_stb   <= '0;
      cfg_err  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
        div[i] <= div_nxt[i];
        if (accept && (cfg_ch == CH_W'(i)))
          nxt[i] <= clamp(cfg_div);
      end
      pending  <= pending_nxt;
      clk_out  <= clk_nxt;
      rise_stb <= rise_nxt;
      tc_stb   <= tc_nxt;
      cfg_err  <= cfg_valid & ~ch_ok;
    end
  end

endmodule

// File: tb/tb_clock_div_gen.sv
// Scoreboard bench for clock_div_gen: a waveform-queue model predicts every cycle, a monitor compares.
// Three channels are instantiated so an out-of-range channel index (3) is representable.
module tb_clock_div_gen;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int INIT [NCH] = '{2, 8, 5};

  logic clk = 1'b0;
  logic rst, sync, cfg_valid, cfg_ready, cfg_err;
  logic [1:0] cfg_ch;
  logic [DW-1:0] cfg_div;
  logic [NCH-1:0] clk_out, rise_stb, tc_stb;
`ifdef CLKGEN_GATE_EN
  logic [NCH-1:0] run_en = '1;
`endif

  clock_div_gen #(
    .NUM_CH(NCH), .DIV_W(DW), .DIV_INIT({8'd5, 8'd8, 8'd2})
  ) dut (
    .clk(clk), .rst(rst), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_err(cfg_err),
`ifdef CLKGEN_GATE_EN
    .run_en(run_en),
`endif
    .clk_out(clk_out), .rise_stb(rise_stb), .tc_stb(tc_stb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] clk_v;
    logic [NCH-1:0] rise_v;
    logic [NCH-1:0] tc_v;
    logic           err_v;
    logic           rdy_v;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: each channel holds the rest of its current period as a queue of
  // {tc, rise, clk} cycles; a new period is generated whenever the queue runs dry.
  int       md    [NCH];
  int       mnxt  [NCH];
  bit       mpend [NCH];
  bit [2:0] wave  [NCH][$];
  bit [2:0] cur   [NCH];
  bit       cur_err;
  bit       model_ok = 0;

  function automatic int clampd(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic void new_period(input int ch);
    int lows, highs;
    lows  = md[ch] / 2;
    highs = md[ch] - lows;
    wave[ch].delete();
    for (int k = 0; k < lows; k++) wave[ch].push_back(3'b000);
    for (int k = 0; k < highs; k++)
      wave[ch].push_back({(k == highs - 1), (k == 0), 1'b1});
  endfunction

  function automatic void model_step(input bit r, input bit s, input bit v, input int ch, input int dv);
    bit acc;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        md[i] = clampd(INIT[i]);
        mpend[i] = 0;
        new_period(i);
        cur[i] = wave[i].pop_front();
      end
      cur_err = 0;
      model_ok = 1;
      return;
    end
    if (!model_ok) return;
    acc = v && (ch < NCH) && !mpend[ch];
    for (int i = 0; i < NCH; i++) begin
      if (s || wave[i].size() == 0) begin
        if (mpend[i]) begin
          md[i] = mnxt[i];
          mpend[i] = 0;
        end
        new_period(i);
      end
      cur[i] = wave[i].pop_front();
    end
    if (acc) begin
      mnxt[ch] = clampd(dv);
      mpend[ch] = 1;
    end
    cur_err = v && (ch >= NCH);
  endfunction

  function automatic bit model_ready(input int ch);
    return (ch >= NCH) ? 1'b1 : !mpend[ch];
  endfunction

  task automatic apply_stimulus(input bit r, input bit s, input bit v, input int ch, input int dv);
    exp_t e;
    rst = r; sync = s; cfg_valid = v;
    cfg_ch = 2'(ch); cfg_div = 8'(dv);
    if (model_ok) begin
      for (int i = 0; i < NCH; i++) begin
        e.clk_v[i]  = cur[i][0];
        e.rise_v[i] = cur[i][1];
        e.tc_v[i]   = cur[i][2];
      end
      e.err_v = cur_err;
      e.rdy_v = model_ready(ch);
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_step(r, s, v, ch, dv);
    #1;
  endtask

  task automatic check_output(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, got, want);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("clk_out", clk_out, e.clk_v);
        check_output("rise_stb", rise_stb, e.rise_v);
        check_output("tc_stb", tc_stb, e.tc_v);
        check_output("cfg_err", {2'b00, cfg_err}, {2'b00, e.err_v});
        check_output("cfg_ready", {2'b00, cfg_ready}, {2'b00, e.rdy_v});
      end
    end
  end

  initial begin
    bit r, s, v, hold;
    int ch, dv, n;
    rst = 1; sync = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0;
    @(posedge clk); #1;

    // Reset default waveforms
    for (int k = 0; k < 3; k++) apply_stimulus(1, 0, 0, 0, 0);
    idle(27);

    // Mid-period update of ch1 to 5, with a second ch1 write stalled until the tc
    apply_stimulus(0, 0, 1, 1, 5);
    n = 0;
    while (mpend[1] && n < 20) begin
      apply_stimulus(0, 0, 1, 1, 3);
      n++;
    end
    apply_stimulus(0, 0, 1, 1, 3);
    idle(20);

    // Clamp of div=0 on ch0, then an out-of-range channel write
    apply_stimulus(0, 0, 1, 0, 0);
    idle(8);
    apply_stimulus(0, 0, 1, 3, 7);
    idle(6);

    // Sync with a pending ch0 update
    apply_stimulus(0, 0, 1, 0, 4);
    idle(3);
    apply_stimulus(0, 1, 0, 0, 0);
    idle(12);

    // rst and sync together while an update is pending
    apply_stimulus(0, 0, 1, 1, 9);
    apply_stimulus(1, 1, 0, 0, 0);
    idle(20);

    // Randomized traffic; the master holds a stalled request stable
    hold = 0; v = 0; ch = 0; dv = 0;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 39) == 0);
      if (!hold) begin
        v  = ($urandom_range(0, 5) == 0);
        ch = $urandom_range(0, 3);
        dv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      end
      hold = v && !model_ready(ch);
      apply_stimulus(r, s, v, ch, dv);
    end
    idle(2);
    @(negedge clk); #1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
